// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Byte-serial controller between the pipeline (MEM loads and
//                stores, IF instruction fetch) and a single-port 8-bit RAM
//                with one cycle of read latency. Each access is split into
//                little-endian byte transactions; load data is assembled and
//                sign-/zero-extended.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   // MEM stage
   input  logic [2:0]        read_i,
   input  logic [1:0]        write_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              read_busy_o,
   output logic              write_busy_o,
   output logic [31:0]       read_data_o,
   // IF stage
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic              if_busy_o,
   output logic              if_done_o,
   output logic [31:0]       if_inst_o,
   // RAM
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_WR      = 3'd2;
   localparam logic [2:0] S_FETCH   = 3'd3;
   localparam logic [2:0] S_DONE_RD = 3'd4;
   localparam logic [2:0] S_DONE_WR = 3'd5;
   localparam logic [2:0] S_DONE_IF = 3'd6;

   localparam logic [2:0] c_LB  = 3'd1;
   localparam logic [2:0] c_LH  = 3'd2;
   localparam logic [2:0] c_LBU = 3'd4;
   localparam logic [2:0] c_LHU = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  r_cnt;      // cycles spent in the active state
   logic [2:0]  r_len;      // byte count of the current transaction
   logic [2:0]  r_ld_code;  // load code latched at acceptance
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_buf;      // bytes received so far, little-endian

   logic        w_rd_valid;
   logic [2:0]  w_rd_len;
   logic [2:0]  w_wr_len;
   logic [2:0]  w_next_cnt;
   logic [1:0]  w_cap_idx;
   logic [1:0]  w_last_idx;
   logic [31:0] w_word;
   logic [31:0] w_ext;

   // Decode request codes into validity and byte counts
   always_comb begin
      w_rd_valid = (read_i != 3'd0) && (read_i <= 3'd5);
      case (read_i)
         c_LB, c_LBU: w_rd_len = 3'd1;
         c_LH, c_LHU: w_rd_len = 3'd2;
         default:     w_rd_len = 3'd4;
      endcase
      case (write_i)
         2'd1:    w_wr_len = 3'd1;
         2'd2:    w_wr_len = 3'd2;
         default: w_wr_len = 3'd4;
      endcase
   end

   // Busy flags are combinational so a stage can stall in the request cycle
   always_comb begin
      read_busy_o  = w_rd_valid && (r_state != S_DONE_RD);
      write_busy_o = (write_i != 2'd0) && (r_state != S_DONE_WR);
      if_busy_o    = (r_state == S_FETCH);
   end

   // Final word: buffered bytes with the last byte taken straight off the RAM
   always_comb begin
      w_next_cnt = r_cnt + 3'd1;
      w_cap_idx  = r_cnt[1:0] - 2'd1;
      w_last_idx = r_len[1:0] - 2'd1;
      w_word     = r_buf;
      w_word[{w_last_idx, 3'b000} +: 8] = ram_din_i;
      case (r_ld_code)
         c_LB:    w_ext = {{24{w_word[7]}}, w_word[7:0]};
         c_LH:    w_ext = {{16{w_word[15]}}, w_word[15:0]};
         c_LBU:   w_ext = {24'd0, w_word[7:0]};
         c_LHU:   w_ext = {16'd0, w_word[15:0]};
         default: w_ext = w_word;
      endcase
   end

   // Arbitration, byte sequencing and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_len       <= 3'd0;
         r_ld_code   <= 3'd0;
         r_addr      <= 32'd0;
         r_wdata     <= 32'd0;
         r_buf       <= 32'd0;
         ram_addr_o  <= '0;
         ram_wr_o    <= 1'b0;
         ram_dout_o  <= 8'd0;
         read_data_o <= 32'd0;
         if_inst_o   <= 32'd0;
         if_done_o   <= 1'b0;
      end else begin
         if_done_o <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 3'd0;
               r_buf <= 32'd0;
               // Stores first, then loads, then fetch; byte 0 issues next cycle
               if (write_i != 2'd0) begin
                  r_state    <= S_WR;
                  r_len      <= w_wr_len;
                  r_addr     <= addr_i;
                  r_wdata    <= wdata_i;
                  ram_wr_o   <= 1'b1;
                  ram_addr_o <= addr_i[ADDR_W-1:0];
                  ram_dout_o <= wdata_i[7:0];
               end else if (w_rd_valid) begin
                  r_state    <= S_RD;
                  r_len      <= w_rd_len;
                  r_ld_code  <= read_i;
                  r_addr     <= addr_i;
                  ram_addr_o <= addr_i[ADDR_W-1:0];
               end else if (if_req_i) begin
                  r_state    <= S_FETCH;
                  r_len      <= 3'd4;
                  r_addr     <= if_addr_i;
                  ram_addr_o <= if_addr_i[ADDR_W-1:0];
               end
            end
            S_RD, S_FETCH: begin
               if (r_cnt == r_len) begin
                  // Last byte arrives now; a dropped request discards the result
                  if (r_state == S_RD) begin
                     r_state <= S_DONE_RD;
                     if (w_rd_valid)
                        read_data_o <= w_ext;
                  end else begin
                     r_state <= S_DONE_IF;
                     if (if_req_i) begin
                        if_inst_o <= w_word;
                        if_done_o <= 1'b1;
                     end
                  end
               end else begin
                  if (r_cnt != 3'd0)
                     r_buf[{w_cap_idx, 3'b000} +: 8] <= ram_din_i;
                  if (w_next_cnt < r_len)
                     ram_addr_o <= ADDR_W'(r_addr + {29'd0, w_next_cnt});
                  r_cnt <= w_next_cnt;
               end
            end
            S_WR: begin
               if (w_next_cnt == r_len) begin
                  r_state    <= S_DONE_WR;
                  ram_wr_o   <= 1'b0;
                  ram_dout_o <= 8'd0;
               end else begin
                  ram_wr_o   <= 1'b1;
                  ram_addr_o <= ADDR_W'(r_addr + {29'd0, w_next_cnt});
                  ram_dout_o <= r_wdata[{w_next_cnt[1:0], 3'b000} +: 8];
                  r_cnt      <= w_next_cnt;
               end
            end
            default: begin
               // DONE_* states last exactly one cycle
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl
//  Description : Directed self-checking bench for mem_ctrl with a behavioural
//                8-bit synchronous RAM (one cycle read latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        read_i = 3'd0;
    logic [1:0]        write_i = 2'd0;
    logic [31:0]       addr_i = 32'd0;
    logic [31:0]       wdata_i = 32'd0;
    logic              read_busy_o;
    logic              write_busy_o;
    logic [31:0]       read_data_o;
    logic              if_req_i = 1'b0;
    logic [31:0]       if_addr_i = 32'd0;
    logic              if_busy_o;
    logic              if_done_o;
    logic [31:0]       if_inst_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int wr_cnt = 0;
    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .read_i(read_i), .write_i(write_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .read_busy_o(read_busy_o), .write_busy_o(write_busy_o), .read_data_o(read_data_o),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_busy_o(if_busy_o),
        .if_done_o(if_done_o), .if_inst_o(if_inst_o),
        .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
        .ram_din_i(ram_din_i)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write on ram_wr_o, registered read of the current address
    always @(posedge clk) begin
        if (ram_wr_o) begin
            mem[ram_addr_o] <= ram_dout_o;
            wr_cnt <= wr_cnt + 1;
        end
        ram_din_i <= mem[ram_addr_o];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a load from an IDLE cycle; returns cycles to completion and the data
    task automatic run_load(input logic [2:0] code, input logic [31:0] a,
                            output int lat, output logic [31:0] d);
        read_i = code;
        addr_i = a;
        lat = 0;
        #1;
        while (read_busy_o && lat < 20) begin
            tick;
            lat++;
        end
        d = read_data_o;
        read_i = 3'd0;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({ram_wr_o, ram_dout_o, ram_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_ram: got wr=%b dout=%h addr=%h required all zero", ram_wr_o, ram_dout_o, ram_addr_o);
        end
        checks++;
        if (read_data_o !== 32'd0 || if_inst_o !== 32'd0 || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_results: got rd=%h inst=%h done=%b required 0/0/0", read_data_o, if_inst_o, if_done_o);
        end
        checks++;
        if ({read_busy_o, write_busy_o, if_busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_busy: got %b required 000", {read_busy_o, write_busy_o, if_busy_o});
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_lw;
        mem[17'h100] <= 8'h78; mem[17'h101] <= 8'h56;
        mem[17'h102] <= 8'h34; mem[17'h103] <= 8'h12;
        tick;
        read_i = 3'd3;
        addr_i = 32'h100;
        #1;
        checks++;
        if (read_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL lw_busy_t0: got %b required 1", read_busy_o);
        end
        for (int k = 1; k <= 5; k++) begin
            tick;
            if (k == 1) addr_i = 32'h0;
            checks++;
            if (read_busy_o !== 1'b1) begin
                errors++;
                $display("FAIL lw_busy_t%0d: got %b required 1", k, read_busy_o);
            end
        end
        tick;
        checks++;
        if (read_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL lw_busy_t6: got %b required 0", read_busy_o);
        end
        checks++;
        if (read_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_data: got %h required 12345678", read_data_o);
        end
        read_i = 3'd0;
        tick;
        checks++;
        if (read_data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL lw_hold: got %h required 12345678", read_data_o);
        end
    endtask

    task automatic test_ext;
        int lat;
        logic [31:0] d;
        mem[17'h20] <= 8'h80;
        mem[17'h22] <= 8'hFE; mem[17'h23] <= 8'hFF;
        tick;
        run_load(3'd1, 32'h20, lat, d);
        checks++;
        if (d !== 32'hFFFFFF80 || lat != 3) begin
            errors++;
            $display("FAIL lb: got %h lat %0d required FFFFFF80 lat 3", d, lat);
        end
        run_load(3'd4, 32'h20, lat, d);
        checks++;
        if (d !== 32'h00000080 || lat != 3) begin
            errors++;
            $display("FAIL lbu: got %h lat %0d required 00000080 lat 3", d, lat);
        end
        run_load(3'd2, 32'h22, lat, d);
        checks++;
        if (d !== 32'hFFFFFFFE || lat != 4) begin
            errors++;
            $display("FAIL lh: got %h lat %0d required FFFFFFFE lat 4", d, lat);
        end
        run_load(3'd5, 32'h22, lat, d);
        checks++;
        if (d !== 32'h0000FFFE || lat != 4) begin
            errors++;
            $display("FAIL lhu: got %h lat %0d required 0000FFFE lat 4", d, lat);
        end
    endtask

    task automatic test_sh;
        int lat;
        logic [31:0] d;
        mem[17'h40] <= 8'h11; mem[17'h41] <= 8'h22;
        mem[17'h42] <= 8'h33; mem[17'h43] <= 8'h44;
        tick;
        write_i = 2'd2;
        addr_i  = 32'h40;
        wdata_i = 32'hABCD1234;
        #1;
        checks++;
        if (write_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL sh_busy_t0: got %b required 1", write_busy_o);
        end
        tick;
        wdata_i = 32'h0;
        checks++;
        if ({ram_wr_o, ram_addr_o, ram_dout_o} !== {1'b1, 17'h40, 8'h34}) begin
            errors++;
            $display("FAIL sh_byte0: got wr=%b addr=%h dout=%h required 1/00040/34", ram_wr_o, ram_addr_o, ram_dout_o);
        end
        tick;
        checks++;
        if ({ram_wr_o, ram_addr_o, ram_dout_o} !== {1'b1, 17'h41, 8'h12}) begin
            errors++;
            $display("FAIL sh_byte1: got wr=%b addr=%h dout=%h required 1/00041/12", ram_wr_o, ram_addr_o, ram_dout_o);
        end
        tick;
        checks++;
        if (write_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL sh_busy_t3: got %b required 0", write_busy_o);
        end
        checks++;
        if ({ram_wr_o, ram_addr_o, ram_dout_o} !== {1'b0, 17'h41, 8'h00}) begin
            errors++;
            $display("FAIL sh_idle_ram: got wr=%b addr=%h dout=%h required 0/00041/00", ram_wr_o, ram_addr_o, ram_dout_o);
        end
        write_i = 2'd0;
        tick;
        run_load(3'd3, 32'h40, lat, d);
        checks++;
        if (d !== 32'h44331234 || lat != 6) begin
            errors++;
            $display("FAIL sh_readback: got %h lat %0d required 44331234 lat 6", d, lat);
        end
    endtask

    task automatic test_back_to_back;
        mem[17'h200] <= 8'hEF; mem[17'h201] <= 8'hBE;
        mem[17'h202] <= 8'hAD; mem[17'h203] <= 8'hDE;
        tick;
        read_i    = 3'd3;
        addr_i    = 32'h100;
        if_req_i  = 1'b1;
        if_addr_i = 32'h200;
        #1;
        checks++;
        if (if_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL arb_ifbusy_t0: got %b required 0", if_busy_o);
        end
        for (int k = 1; k <= 13; k++) begin
            tick;
            if (k == 6) begin
                checks++;
                if (read_busy_o !== 1'b0 || read_data_o !== 32'h12345678) begin
                    errors++;
                    $display("FAIL arb_lw_done: got busy=%b data=%h required 0/12345678", read_busy_o, read_data_o);
                end
                read_i = 3'd0;
            end
            checks++;
            if (if_busy_o !== (k >= 8 && k <= 12)) begin
                errors++;
                $display("FAIL arb_ifbusy_t%0d: got %b required %b", k, if_busy_o, (k >= 8 && k <= 12));
            end
            checks++;
            if (if_done_o !== (k == 13)) begin
                errors++;
                $display("FAIL arb_ifdone_t%0d: got %b required %b", k, if_done_o, (k == 13));
            end
        end
        checks++;
        if (if_inst_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL arb_inst: got %h required DEADBEEF", if_inst_o);
        end
        if_req_i = 1'b0;
        tick;
    endtask

    task automatic test_fetch_wrap;
        logic [ADDR_W-1:0] exp_a [4];
        exp_a = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};
        mem[17'h1FFFE] <= 8'h11; mem[17'h1FFFF] <= 8'h22;
        mem[17'h00000] <= 8'h33; mem[17'h00001] <= 8'h44;
        tick;
        if_req_i  = 1'b1;
        if_addr_i = 32'hFFFFFFFE;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k <= 4) begin
                checks++;
                if (ram_addr_o !== exp_a[k-1]) begin
                    errors++;
                    $display("FAIL wrap_addr_t%0d: got %h required %h", k, ram_addr_o, exp_a[k-1]);
                end
            end
        end
        checks++;
        if (if_done_o !== 1'b1 || if_inst_o !== 32'h44332211) begin
            errors++;
            $display("FAIL wrap_inst: got done=%b inst=%h required 1/44332211", if_done_o, if_inst_o);
        end
        if_req_i = 1'b0;
        tick;
        checks++;
        if (if_done_o !== 1'b0 || if_inst_o !== 32'h44332211) begin
            errors++;
            $display("FAIL wrap_hold: got done=%b inst=%h required 0/44332211", if_done_o, if_inst_o);
        end
    endtask

    task automatic test_reset_mid_sw;
        int base;
        base    = wr_cnt;
        write_i = 2'd3;
        addr_i  = 32'h300;
        wdata_i = 32'hA1B2C3D4;
        tick;
        tick;
        rst     = 1'b1;
        write_i = 2'd0;
        tick;
        checks++;
        if (wr_cnt - base != 2) begin
            errors++;
            $display("FAIL rstsw_writes: got %0d required 2", wr_cnt - base);
        end
        checks++;
        if ({ram_wr_o, ram_dout_o, ram_addr_o} !== '0) begin
            errors++;
            $display("FAIL rstsw_ram: got wr=%b dout=%h addr=%h required all zero", ram_wr_o, ram_dout_o, ram_addr_o);
        end
        checks++;
        if (read_data_o !== 32'd0 || if_inst_o !== 32'd0 || if_done_o !== 1'b0) begin
            errors++;
            $display("FAIL rstsw_results: got rd=%h inst=%h done=%b required 0/0/0", read_data_o, if_inst_o, if_done_o);
        end
        checks++;
        if ({read_busy_o, write_busy_o, if_busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL rstsw_busy: got %b required 000", {read_busy_o, write_busy_o, if_busy_o});
        end
        rst = 1'b0;
        tick;
        tick;
        checks++;
        if (wr_cnt - base != 2 || mem[17'h300] !== 8'hD4 || mem[17'h301] !== 8'hC3 || mem[17'h302] !== 8'h00) begin
            errors++;
            $display("FAIL rstsw_mem: got n=%0d %h %h %h required 2 D4 C3 00",
                     wr_cnt - base, mem[17'h300], mem[17'h301], mem[17'h302]);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 8'h00;
        test_reset;
        test_lw;
        test_ext;
        test_sh;
        test_back_to_back;
        test_fetch_wrap;
        test_reset_mid_sw;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the single-port 8-bit RAM. Serves two clients: the MEM stage (data loads and stores, driven by its `read_o`/`write_o` request outputs) and the IF stage (32-bit instruction fetch). It serialises each access into byte transactions, assembles and sign-/zero-extends load data, and reports busy/done so both stages can stall.

## Interface
Parameters:
- ADDR_W, 17, RAM address width; `ram_addr_o` carries the low ADDR_W bits of the byte address.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- read_i  in  3  MEM load code: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6 and 7 are treated as none
- write_i  in  2  MEM store code: 0 none, 1 SB, 2 SH, 3 SW
- addr_i  in  32  MEM byte address, load or store
- wdata_i  in  32  MEM store data; low bytes are used
- read_busy_o  out  1  MEM load pending, not complete
- write_busy_o  out  1  MEM store pending, not complete
- read_data_o  out  32  extended load result; valid in the completion cycle
- if_req_i  in  1  fetch request, level
- if_addr_i  in  32  fetch byte address
- if_busy_o  out  1  fetch accepted, not complete
- if_done_o  out  1  one-cycle pulse; `if_inst_o` is valid in that cycle
- if_inst_o  out  32  fetched word
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  1 = write `ram_dout_o`
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte; 1-cycle latency after its address

## Operation
- States: IDLE, RD, WR, FETCH, DONE_RD, DONE_WR, DONE_IF.
- IDLE arbitration, in priority order:
  - store (`write_i != 0`) → WR
  - load → RD
  - `if_req_i` → FETCH
- MEM always wins over IF. A transaction in progress is never preempted.
- Byte count N: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW/fetch.
- Byte k is at address latched_addr + k, computed in 32 bits; wrap at 2^32, truncated to ADDR_W.
- Byte order is little-endian. Byte k of the store data is `wdata_i[8k+7:8k]`.
- Address and data are latched at acceptance. Later changes on the inputs do not affect the transaction.
- Loads:
  - LB/LH: sign-extend from bit 7 / bit 15.
  - LBU/LHU: zero-extend.
  - LW: no extension.
- Busy outputs are combinational:
  - `read_busy_o = (read_i valid) && !(state == DONE_RD)`
  - `write_busy_o = (write_i != 0) && !(state == DONE_WR)`
  - `if_busy_o` is high in FETCH.
- Once started, a transaction runs to completion even if its request drops. Result is discarded if no request is present at completion.
- DONE_* lasts one cycle, then returns to IDLE. New arbitration happens in the following IDLE cycle.
- Requester rule: after its completion cycle, the MEM stage either advances or deasserts. A request still held in IDLE is treated as a new access.
- When not issuing a write byte: `ram_wr_o = 0`, `ram_dout_o = 0`, `ram_addr_o` holds its last value.
- rst mid-transaction aborts it. Remaining RAM writes are not issued.

## Timing
- Reset values:
  - state = IDLE
  - `ram_wr_o = 0`, `ram_addr_o = 0`, `ram_dout_o = 0`
  - `read_data_o = 0`, `if_inst_o = 0`, `if_done_o = 0`
  - busy outputs follow the combinational rules above with state IDLE
- Request first seen in IDLE at cycle t.
- Read/fetch:
  - Addresses are issued in cycles t+1..t+N.
  - Bytes arrive in t+2..t+N+1 and are registered.
  - DONE at t+N+2: `read_data_o` / `if_inst_o` valid, and `read_busy_o` low or `if_done_o` high.
  - LW or fetch: 6 cycles from request to completion.
- Write:
  - `ram_wr_o` is high in t+1..t+N, one byte per cycle.
  - DONE_WR at t+N+1, `write_busy_o` low. SW completes in 5 cycles.
- IF request waiting behind MEM: IF is accepted in the IDLE cycle after DONE_*.
- `read_data_o` holds its value after DONE_RD until the next load completes. `if_inst_o` behaves the same for fetches.

## Test plan
- LW at 0x100, RAM[0x100..0x103] = 78 56 34 12 → `read_busy_o` high t..t+5; at t+6 `read_busy_o` = 0 and `read_data_o` = 0x12345678.
- LB at 0x20 = 0x80 → 0xFFFFFF80; LBU same address → 0x00000080; LH at 0x22, bytes FE FF → 0xFFFFFFFE.
- SH 0xABCD1234 at 0x40 → `ram_wr_o` pulses at 0x40 (0x34) and 0x41 (0x12), `write_busy_o` low at t+3; following LW at 0x40 → 0x????1234 with the upper bytes unchanged.
- IF and LW requested in the same IDLE cycle → LW completes at t+6, fetch accepted at t+7, `if_done_o` pulse at t+13 with the correct word; `if_busy_o` low until t+8.
- SW in progress, rst asserted after 2 bytes → exactly 2 RAM writes issued, state IDLE next cycle, all outputs at reset values.
- Fetch at 0xFFFFFFFE → byte addresses wrap to 0xFFFFFFFF, 0x0, 0x1 (truncated to ADDR_W); assembled word is correct.
